mem_arbiter: RTL and testbench

//  Single-port memory controller between the CPU's instruction-fetch and data

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises instruction fetches and data accesses
// onto one RAM port, alternates priority on conflict and owns the LL/SC link.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              iren_i,
    input  logic [ADDR_W-1:0] iaddr_i,
    output logic              iwait_o,
    output logic [DATA_W-1:0] iload_o,
    input  logic              dren_i,
    input  logic              dwen_i,
    input  logic              datomic_i,
    input  logic [ADDR_W-1:0] daddr_i,
    input  logic [DATA_W-1:0] dstore_i,
    output logic              dwait_o,
    output logic [DATA_W-1:0] dload_o,
    output logic              ram_ren_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_store_o,
    input  logic [DATA_W-1:0] ram_load_i,
    input  logic              ram_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_INSTR = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:2] link_addr_q, link_addr_d;

    logic d_req;
    logic sc_req;
    logic link_hit;
    logic grant_data;

    assign d_req      = dren_i | dwen_i;
    assign sc_req     = dwen_i & datomic_i;
    assign link_hit   = link_valid_q && (link_addr_q == daddr_i[ADDR_W-1:2]);
    // On conflict the data side wins only if instruction fetch was served last.
    assign grant_data = d_req && (!iren_i || (last_grant_q == GRANT_I));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_D;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        iwait_o      = 1'b1;
        iload_o      = '0;
        dwait_o      = 1'b1;
        dload_o      = '0;
        ram_ren_o    = 1'b0;
        ram_wen_o    = 1'b0;
        ram_addr_o   = '0;
        ram_store_o  = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    last_grant_d = GRANT_D;
                    if (sc_req && !link_hit) begin
                        // Failed SC completes here without touching RAM.
                        dwait_o      = 1'b0;
                        link_valid_d = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (iren_i) begin
                    last_grant_d = GRANT_I;
                    state_d      = ST_INSTR;
                end
            end

            ST_DATA: begin
                ram_addr_o  = daddr_i;
                ram_wen_o   = dwen_i;
                ram_ren_o   = dren_i & ~dwen_i;
                ram_store_o = dstore_i;
                if (ram_ready_i) begin
                    dwait_o = 1'b0;
                    state_d = ST_IDLE;
                    if (dwen_i) begin
                        dload_o = {{(DATA_W-1){1'b0}}, datomic_i};
                        if (datomic_i || (link_addr_q == daddr_i[ADDR_W-1:2])) begin
                            link_valid_d = 1'b0;
                        end
                    end else begin
                        dload_o = ram_load_i;
                        if (datomic_i) begin
                            link_valid_d = 1'b1;
                            link_addr_d  = daddr_i[ADDR_W-1:2];
                        end
                    end
                end
            end

            ST_INSTR: begin
                ram_addr_o = iaddr_i;
                ram_ren_o  = 1'b1;
                if (ram_ready_i) begin
                    iwait_o = 1'b0;
                    iload_o = ram_load_i;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model checks every
// cycle, and directed scenarios pin reset, arbitration and LL/SC outcomes.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        iren, dren, dwen, datomic;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait;
    logic [31:0] iload, dload;
    logic        ram_ren, ram_wen, ram_ready;
    logic [31:0] ram_addr, ram_store, ram_load;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .iren_i     (iren),
        .iaddr_i    (iaddr),
        .iwait_o    (iwait),
        .iload_o    (iload),
        .dren_i     (dren),
        .dwen_i     (dwen),
        .datomic_i  (datomic),
        .daddr_i    (daddr),
        .dstore_i   (dstore),
        .dwait_o    (dwait),
        .dload_o    (dload),
        .ram_ren_o  (ram_ren),
        .ram_wen_o  (ram_wen),
        .ram_addr_o (ram_addr),
        .ram_store_o(ram_store),
        .ram_load_i (ram_load),
        .ram_ready_i(ram_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RAM: word array with programmable latency measured in strobe cycles.
    logic [31:0] mem [0:255];
    int          lat = 1;
    int          ram_cnt = 0;

    always @(posedge clk) begin
        if (ram_ready && ram_wen) mem[ram_addr[9:2]] = ram_store;
        if (ram_ready || !(ram_ren || ram_wen)) ram_cnt = 0;
        else ram_cnt++;
        #2;
        ram_ready = (ram_ren || ram_wen) && (ram_cnt == lat - 1);
        ram_load  = (ram_ren || ram_wen) ? mem[ram_addr[9:2]] : 32'h0;
    end

    // Reference model: which side owns the RAM (0 none, 1 data, 2 fetch),
    // who was served last, and the link. Evaluated mid-cycle on stable inputs.
    int          m_owner = 0;
    bit          m_last_data = 1'b1;
    bit          m_link_v = 1'b0;
    bit          m_valid = 1'b0;
    logic [29:0] m_link_a = '0;
    logic        e_ren, e_wen, e_iwait, e_dwait;
    logic [31:0] e_addr, e_store, e_iload, e_dload;
    bit          m_give_data, m_give_instr, m_sc_fail;

    always @(negedge clk) begin
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        e_iwait = 1; e_dwait = 1; e_iload = 0; e_dload = 0;
        m_give_data  = (dren || dwen) && (!iren || !m_last_data);
        m_give_instr = !m_give_data && iren;
        m_sc_fail    = m_give_data && dwen && datomic && !(m_link_v && m_link_a == daddr[31:2]);
        if (m_owner == 0) begin
            if (m_sc_fail) e_dwait = 0;
        end else if (m_owner == 1) begin
            e_addr = daddr; e_wen = dwen; e_ren = dren && !dwen; e_store = dstore;
            if (ram_ready) begin
                e_dwait = 0;
                e_dload = dwen ? {31'b0, datomic} : ram_load;
            end
        end else begin
            e_addr = iaddr; e_ren = 1;
            if (ram_ready) begin
                e_iwait = 0;
                e_iload = ram_load;
            end
        end

        if (m_valid) begin
            check("ram_ren", ram_ren, e_ren);
            check("ram_wen", ram_wen, e_wen);
            check("ram_addr", ram_addr, e_addr);
            check("ram_store", ram_store, e_store);
            check("iwait", iwait, e_iwait);
            check("dwait", dwait, e_dwait);
            check("iload", iload, e_iload);
            check("dload", dload, e_dload);
        end

        if (rst) begin
            m_owner = 0; m_last_data = 1; m_link_v = 0; m_link_a = '0; m_valid = 1;
        end else if (m_owner == 0) begin
            if (m_give_data) begin
                m_last_data = 1;
                if (m_sc_fail) m_link_v = 0;
                else m_owner = 1;
            end else if (m_give_instr) begin
                m_last_data = 0;
                m_owner = 2;
            end
        end else if (ram_ready) begin
            if (m_owner == 1) begin
                if (dwen && (datomic || m_link_a == daddr[31:2])) m_link_v = 0;
                if (!dwen && datomic) begin
                    m_link_v = 1;
                    m_link_a = daddr[31:2];
                end
            end
            m_owner = 0;
        end
    end

    task automatic do_data(input bit wr, input bit at, input logic [31:0] a, input logic [31:0] s,
                           output logic [31:0] res, output int cyc, output time t_done);
        @(posedge clk); #1;
        dren = !wr; dwen = wr; datomic = at; daddr = a; dstore = s;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (dwait && cyc < 40);
        check("data_done", dwait, 1'b0);
        res = dload;
        t_done = $time;
        @(posedge clk); #1;
        dren = 0; dwen = 0; datomic = 0;
    endtask

    task automatic do_fetch(input logic [31:0] a, output logic [31:0] res, output int cyc,
                            output time t_done);
        @(posedge clk); #1;
        iren = 1; iaddr = a;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (iwait && cyc < 40);
        check("fetch_done", iwait, 1'b0);
        res = iload;
        t_done = $time;
        @(posedge clk); #1;
        iren = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd, rf;
    int          cd, cf;
    time         td, tf;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | i;
        mem[16] = 32'h2108_0004;
        rst = 1; iren = 1; iaddr = 32'h40;
        dren = 0; dwen = 0; datomic = 0; daddr = 0; dstore = 0;
        ram_ready = 0; ram_load = 0;
        lat = 3;

        // Reset held two edges with a fetch pending.
        @(posedge clk);
        @(negedge clk);
        check("rst_ram_ren", ram_ren, 1'b0);
        check("rst_iwait", iwait, 1'b1);
        @(posedge clk); #1;
        rst = 0;
        cf = 0;
        do begin
            @(negedge clk);
            cf++;
            if (cf >= 2 && iwait) check("fetch_ram_addr", ram_addr, 32'h40);
        end while (iwait && cf < 40);
        check("fetch_cycles", cf, 4);
        check("fetch_iload", iload, 32'h2108_0004);
        @(posedge clk); #1;
        iren = 0;
        @(negedge clk);
        check("iwait_one_cycle", iwait, 1'b1);

        // Conflict after a fetch: data first, then instruction.
        lat = 1;
        fork
            do_data(0, 0, 32'h80, 0, rd, cd, td);
            do_fetch(32'h44, rf, cf, tf);
        join
        check("conflict1_data_first", td < tf, 1'b1);
        check("conflict1_dload", rd, 32'hA5A5_0020);
        check("conflict1_iload", rf, 32'hA5A5_0011);

        // After a lone data read, conflict goes to the instruction side.
        do_data(0, 0, 32'h84, 0, rd, cd, td);
        check("lone_read_latency", cd, 2);
        fork
            do_data(0, 0, 32'h88, 0, rd, cd, td);
            do_fetch(32'h48, rf, cf, tf);
        join
        check("conflict2_instr_first", tf < td, 1'b1);
        check("conflict2_dload", rd, 32'hA5A5_0022);

        // Sustained contention: neither side waits long.
        fork
            for (int k = 0; k < 12; k++) begin
                logic [31:0] r1; int c1; time t1;
                do_fetch(32'h200 + 4 * k, r1, c1, t1);
                check("fetch_no_starve", c1 <= 4, 1'b1);
            end
            for (int k = 0; k < 12; k++) begin
                logic [31:0] r2; int c2; time t2;
                do_data(0, 0, 32'h300 + 4 * k, 0, r2, c2, t2);
                check("data_no_starve", c2 <= 4, 1'b1);
            end
        join

        // LL then SC succeeds; repeated SC fails fast.
        do_data(0, 1, 32'h100, 0, rd, cd, td);
        check("ll_latency", cd, 2);
        do_data(1, 1, 32'h100, 32'd5, rd, cd, td);
        check("sc_pass_dload", rd, 32'd1);
        check("sc_pass_mem", mem[64], 32'd5);
        do_data(1, 1, 32'h100, 32'd9, rd, cd, td);
        check("sc_fail_dload", rd, 32'd0);
        check("sc_fail_fast", cd, 1);
        check("sc_fail_mem", mem[64], 32'd5);

        // Store to the linked word breaks the link.
        do_data(0, 1, 32'h100, 0, rd, cd, td);
        do_data(1, 0, 32'h100, 32'd7, rd, cd, td);
        do_data(1, 1, 32'h100, 32'd8, rd, cd, td);
        check("sc_after_sw_same", rd, 32'd0);
        check("sc_after_sw_same_mem", mem[64], 32'd7);

        // Store to a different word keeps the link.
        do_data(0, 1, 32'h100, 0, rd, cd, td);
        do_data(1, 0, 32'h104, 32'd3, rd, cd, td);
        do_data(1, 1, 32'h100, 32'd11, rd, cd, td);
        check("sc_after_sw_other", rd, 32'd1);
        check("sc_after_sw_other_mem", mem[64], 32'd11);
        check("sw_other_mem", mem[65], 32'd3);

        // Reset while a store waits on RAM: abandoned, link cleared.
        do_data(0, 1, 32'h100, 0, rd, cd, td);
        lat = 10;
        @(posedge clk); #1;
        dwen = 1; daddr = 32'h200; dstore = 32'h77;
        repeat (3) begin
            @(negedge clk);
            check("pre_rst_dwait", dwait, 1'b1);
        end
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("rst_cycle_dwait", dwait, 1'b1);
        check("rst_cycle_ram_wen", ram_wen, 1'b1);
        @(posedge clk); #1;
        rst = 0; dwen = 0;
        @(negedge clk);
        check("post_rst_ram_wen", ram_wen, 1'b0);
        check("post_rst_dwait", dwait, 1'b1);
        lat = 1;
        do_data(1, 1, 32'h100, 32'd13, rd, cd, td);
        check("sc_after_rst", rd, 32'd0);
        check("sc_after_rst_fast", cd, 1);
        check("abandoned_store_mem", mem[128], 32'hA5A5_0080);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
